// File: rtl/sample_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : sample_packetizer
// Brief    : Buffers 24-bit ADC samples and streams each as a 6-byte packet
//            (HEADER, SEQ, S[23:16], S[15:8], S[7:0], CK) over valid/ready.
// Revision : 1.0
// ============================================================================
module sample_packetizer #(
    parameter int         DEPTH  = 16,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                     clock_i,
    input  logic                     reset_L_i,
    input  logic                     sample_valid_i,
    input  logic [23:0]              sample_i,
    input  logic                     flush_i,
    input  logic                     clear_overflow_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_count_o
);

    localparam int                c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]     c_CNT_ONE   = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]   c_PTR_ONE   = c_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_SEQ  = 3'd2,
        S_B2   = 3'd3,
        S_B1   = 3'd4,
        S_B0   = 3'd5,
        S_CK   = 3'd6
    } state_t;

    logic [23:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    state_t          r_state;
    state_t          w_state_next;
    logic [23:0]     r_hold;
    logic [23:0]     w_hold_next;
    logic [7:0]      r_seq;
    logic [7:0]      w_seq_next;
    logic [7:0]      r_tx_data;
    logic [7:0]      w_tx_data_next;
    logic            r_tx_valid;
    logic            w_tx_valid_next;
    logic            r_overflow;
    logic [7:0]      r_drop_count;

    logic            w_xfer;
    logic            w_has_data;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_drop;

    assign w_xfer     = r_tx_valid & tx_ready_i;
    assign w_has_data = (r_count != '0) & ~flush_i;

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign w_push_req = sample_valid_i & ~flush_i;
    assign w_push     = w_push_req & ((r_count != c_DEPTH_CNT) | w_pop);
    assign w_drop     = w_push_req & ~w_push;

    assign w_hold_next = w_pop ? r_mem[r_rd_ptr] : r_hold;

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_seq_next   = r_seq;
        case (r_state)
            S_IDLE: begin
                if (w_has_data) begin
                    w_pop        = 1'b1;
                    w_state_next = S_HDR;
                end
            end
            S_HDR:  if (w_xfer) w_state_next = S_SEQ;
            S_SEQ:  if (w_xfer) w_state_next = S_B2;
            S_B2:   if (w_xfer) w_state_next = S_B1;
            S_B1:   if (w_xfer) w_state_next = S_B0;
            S_B0:   if (w_xfer) w_state_next = S_CK;
            S_CK: begin
                if (w_xfer) begin
                    w_seq_next = r_seq + 8'd1;
                    if (w_has_data) begin
                        w_pop        = 1'b1;
                        w_state_next = S_HDR;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output byte is looked up from the next state so tx_data_o/tx_valid_o are flops.
    always_comb begin
        w_tx_valid_next = (w_state_next != S_IDLE);
        w_tx_data_next  = 8'h00;
        case (w_state_next)
            S_HDR:   w_tx_data_next = HEADER;
            S_SEQ:   w_tx_data_next = w_seq_next;
            S_B2:    w_tx_data_next = w_hold_next[23:16];
            S_B1:    w_tx_data_next = w_hold_next[15:8];
            S_B0:    w_tx_data_next = w_hold_next[7:0];
            S_CK:    w_tx_data_next = w_seq_next ^ w_hold_next[23:16]
                                    ^ w_hold_next[15:8] ^ w_hold_next[7:0];
            default: w_tx_data_next = 8'h00;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_seq      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold     <= w_hold_next;
            r_seq      <= w_seq_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
        end
    end

    always_ff @(posedge clock_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow_i) begin
                r_drop_count <= 8'd1;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end else if (clear_overflow_i) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign tx_data_o    = r_tx_data;
    assign tx_valid_o   = r_tx_valid;
    assign fifo_count_o = r_count;
    assign busy_o       = (r_state != S_IDLE);
    assign overflow_o   = r_overflow;
    assign drop_count_o = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_sample_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_packetizer
// Brief    : Scoreboard bench: sample queue model, packet monitor, directed
//            and randomized scenarios for sample_packetizer.
// Revision : 1.0
// ============================================================================
module tb_sample_packetizer;

    localparam int         c_DEPTH = 4;
    localparam logic [7:0] c_HDR   = 8'hA5;

    logic        r_clk          = 1'b0;
    logic        r_rst_n        = 1'b0;
    logic        r_sample_valid = 1'b0;
    logic [23:0] r_sample       = '0;
    logic        r_flush        = 1'b0;
    logic        r_clear        = 1'b0;
    logic        r_tx_ready     = 1'b0;
    logic [7:0]  w_tx_data;
    logic        w_tx_valid;
    logic [2:0]  w_fifo_count;
    logic        w_busy;
    logic        w_overflow;
    logic [7:0]  w_drop_count;

    sample_packetizer #(.DEPTH(c_DEPTH), .HEADER(c_HDR)) u_dut (
        .clock_i          (r_clk),
        .reset_L_i        (r_rst_n),
        .sample_valid_i   (r_sample_valid),
        .sample_i         (r_sample),
        .flush_i          (r_flush),
        .clear_overflow_i (r_clear),
        .tx_data_o        (w_tx_data),
        .tx_valid_o       (w_tx_valid),
        .tx_ready_i       (r_tx_ready),
        .fifo_count_o     (w_fifo_count),
        .busy_o           (w_busy),
        .overflow_o       (w_overflow),
        .drop_count_o     (w_drop_count)
    );

    always #5 r_clk = ~r_clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [23:0] samp_q [$];
    logic [7:0]  got_q  [$];
    int          got_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input logic [7:0] seq, input logic [23:0] s, input int idx);
        case (idx)
            0:       return c_HDR;
            1:       return seq;
            2:       return s[23:16];
            3:       return s[15:8];
            4:       return s[7:0];
            default: return seq ^ s[23:16] ^ s[15:8] ^ s[7:0];
        endcase
    endfunction

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic send(input logic [23:0] s, input bit accepted);
        r_sample_valid = 1'b1;
        r_sample       = s;
        if (accepted) samp_q.push_back(s);
        step();
        r_sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (got_q.size() < n) begin
            failures++;
            $display("FAIL timeout_bytes: got %0d bytes expected %0d", got_q.size(), n);
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial forever begin
        @(posedge r_clk);
        cyc++;
    end

    // Monitor: each accepted byte is compared against the packet built from the model queue.
    int          m_pos  = 0;
    logic [7:0]  m_seq  = '0;
    logic [23:0] m_cur  = '0;
    logic        m_hold = 1'b0;
    logic [7:0]  m_held = '0;
    initial forever begin
        @(negedge r_clk);
        if (!r_rst_n) begin
            m_pos  = 0;
            m_seq  = '0;
            m_hold = 1'b0;
        end else begin
            if (m_hold) begin
                check("hold_valid", 32'(w_tx_valid), 32'd1);
                check("hold_data", 32'(w_tx_data), 32'(m_held));
            end
            if (w_tx_valid && r_tx_ready) begin
                if (m_pos == 0) begin
                    if (samp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %0h expected no transfer", w_tx_data);
                        m_cur = '0;
                    end else begin
                        m_cur = samp_q.pop_front();
                    end
                end
                check("pkt_byte", 32'(w_tx_data), 32'(pkt_byte(m_seq, m_cur, m_pos)));
                got_q.push_back(w_tx_data);
                got_cyc.push_back(cyc);
                m_pos++;
                if (m_pos == 6) begin
                    m_pos = 0;
                    m_seq = m_seq + 8'd1;
                end
            end
            m_hold = w_tx_valid && !r_tx_ready;
            m_held = w_tx_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e_pk [12];
        int sent;
        int k;
        e_pk = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h70,
                 8'hA5, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h88};

        // Reset values
        repeat (3) step();
        check("rst_valid", 32'(w_tx_valid), 32'd0);
        check("rst_data", 32'(w_tx_data), 32'd0);
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_ovf", 32'(w_overflow), 32'd0);
        check("rst_drop", 32'(w_drop_count), 32'd0);
        check("rst_count", 32'(w_fifo_count), 32'd0);
        r_rst_n = 1'b1;
        step();

        // Latency and back-to-back packets
        r_tx_ready = 1'b1;
        clear_log();
        send(24'h123456, 1'b1);
        check("lat_c1_valid", 32'(w_tx_valid), 32'd0);
        step();
        check("lat_c2_valid", 32'(w_tx_valid), 32'd1);
        check("lat_c2_data", 32'(w_tx_data), 32'(c_HDR));
        step();
        send(24'hABCDEF, 1'b1);
        wait_bytes(12, 100);
        for (int i = 0; i < 12; i++) check("b2b_byte", 32'(got_q[i]), 32'(e_pk[i]));
        check("no_idle_gap", 32'(got_cyc[6] - got_cyc[5]), 32'd1);
        check("idle_busy", 32'(w_busy), 32'd0);
        check("idle_valid", 32'(w_tx_valid), 32'd0);

        // Backpressure in B1
        clear_log();
        send(24'h123456, 1'b1);
        wait_bytes(3, 50);
        r_tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 32'(w_tx_valid), 32'd1);
            check("bp_data", 32'(w_tx_data), 32'h34);
        end
        r_tx_ready = 1'b1;
        wait_bytes(6, 50);
        check("bp_seq", 32'(got_q[1]), 32'h02);
        check("bp_b0", 32'(got_q[4]), 32'h56);
        check("bp_ck", 32'(got_q[5]), 32'h72);

        // Overflow with the link stalled
        r_rst_n = 1'b0;
        samp_q.delete();
        repeat (2) step();
        r_rst_n = 1'b1;
        step();
        clear_log();
        r_tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(24'(24'h100000 + i + 1), (i < 5));
        check("ovf_count", 32'(w_fifo_count), 32'd4);
        check("ovf_flag", 32'(w_overflow), 32'd1);
        check("ovf_drop", 32'(w_drop_count), 32'd1);
        r_clear = 1'b1;
        send(24'hDEAD00, 1'b0);
        r_clear = 1'b0;
        check("clr_drop_wins_flag", 32'(w_overflow), 32'd1);
        check("clr_drop_wins_cnt", 32'(w_drop_count), 32'd1);
        r_clear = 1'b1;
        step();
        r_clear = 1'b0;
        check("clr_flag", 32'(w_overflow), 32'd0);
        check("clr_cnt", 32'(w_drop_count), 32'd0);
        r_tx_ready = 1'b1;
        wait_bytes(30, 100);
        for (int i = 0; i < 5; i++) begin
            check("drain_seq", 32'(got_q[6*i+1]), 32'(i));
            check("drain_lsb", 32'(got_q[6*i+4]), 32'(i + 1));
        end

        // Random traffic through SEQ wrap
        r_rst_n = 1'b0;
        samp_q.delete();
        repeat (2) step();
        r_rst_n = 1'b1;
        step();
        clear_log();
        sent = 0;
        k = 0;
        while ((sent < 257 || got_q.size() < 257*6) && k < 20000) begin
            r_tx_ready = ($urandom_range(3) != 0);
            if (sent < 257 && samp_q.size() < c_DEPTH && $urandom_range(1) == 1) begin
                r_sample_valid = 1'b1;
                r_sample       = 24'($urandom());
                samp_q.push_back(r_sample);
                sent++;
            end else begin
                r_sample_valid = 1'b0;
            end
            step();
            k++;
        end
        r_sample_valid = 1'b0;
        r_tx_ready     = 1'b1;
        check("wrap_total", 32'(got_q.size()), 32'(257*6));
        check("wrap_seq_ff", 32'(got_q[255*6+1]), 32'hFF);
        check("wrap_seq_00", 32'(got_q[256*6+1]), 32'h00);
        check("wrap_ck", 32'(got_q[256*6+5]),
              32'(got_q[256*6+1] ^ got_q[256*6+2] ^ got_q[256*6+3] ^ got_q[256*6+4]));

        // Reset mid-packet
        repeat (5) step();
        clear_log();
        send(24'h111111, 1'b1);
        send(24'h222222, 1'b1);
        send(24'h333333, 1'b1);
        wait_bytes(2, 50);
        r_rst_n = 1'b0;
        samp_q.delete();
        #1;
        check("rstmid_valid", 32'(w_tx_valid), 32'd0);
        check("rstmid_count", 32'(w_fifo_count), 32'd0);
        check("rstmid_busy", 32'(w_busy), 32'd0);
        repeat (2) step();
        r_rst_n = 1'b1;
        step();
        clear_log();
        send(24'h0F0F0F, 1'b1);
        wait_bytes(6, 50);
        check("rstmid_hdr", 32'(got_q[0]), 32'(c_HDR));
        check("rstmid_seq", 32'(got_q[1]), 32'h00);

        // Flush with queued samples during a packet
        repeat (3) step();
        clear_log();
        send(24'hAAAAAA, 1'b1);
        send(24'hBBBBBB, 1'b1);
        send(24'hCCCCCC, 1'b1);
        send(24'hDDDDDD, 1'b1);
        check("pre_flush_count", 32'(w_fifo_count), 32'd3);
        r_flush = 1'b1;
        samp_q.delete();
        step();
        r_flush = 1'b0;
        check("flush_count", 32'(w_fifo_count), 32'd0);
        wait_bytes(6, 50);
        repeat (10) step();
        check("flush_bytes", 32'(got_q.size()), 32'd6);
        check("flush_b2", 32'(got_q[2]), 32'hAA);
        check("flush_valid", 32'(w_tx_valid), 32'd0);
        check("flush_busy", 32'(w_busy), 32'd0);
        check("flush_count_end", 32'(w_fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
